counter_up_down_mod_nbit: RTL and testbench
===========================================

# counter_up_down_mod_nbit

Parametrised up/down counter with programmable modulus, variable step, selectable overflow mode (wrap, saturate, one-shot), synchronous load, terminal-count pulse and sticky over/underflow flags. Next generation of the team's loadable up/down counter. Used as a general timebase, event counter or address sequencer wherever a non-power-of-two range or a stop-at-limit behaviour is needed.

## Interface
- CNT_WIDTH, 8, counter width in bits
- CNT_MAX, 2**CNT_WIDTH-1, largest legal count; the range is 0..CNT_MAX; must satisfy 1 <= CNT_MAX <= 2**CNT_WIDTH-1
- STEP_WIDTH, 2, width of the step input; must satisfy 2**STEP_WIDTH-1 <= CNT_MAX
- clk  in  1  single clock; all state changes on its rising edge
- reset_n  in  1  reset, synchronous, active-low
- enable  in  1  count enable; when low, no count step occurs
- load_en  in  1  synchronous load of counter_in
- counter_in  in  CNT_WIDTH  load value
- up_down  in  1  1 = count up, 0 = count down
- step  in  STEP_WIDTH  increment/decrement amount per enabled cycle (0 allowed)
- mode  in  2  00 = wrap, 01 = saturate, 10 = one-shot, 11 = reserved (behaves as wrap)
- clr_flags  in  1  clears ovf/unf
- counter_out  out  CNT_WIDTH  registered count
- tc  out  1  registered one-cycle terminal-count pulse
- ovf  out  1  sticky: an up step exceeded CNT_MAX
- unf  out  1  sticky: a down step went below 0
- done  out  1  high while the one-shot FSM is in DONE

## Operation
- Priority per edge: reset_n low > load_en > count step (enable) > hold.
- Load: counter_out <= min(counter_in, CNT_MAX). FSM goes to RUN, done = 0, tc = 0. Flags are not changed. A load takes effect even when enable = 0.
- Count step occurs only when enable = 1, load_en = 0 and FSM = RUN.
- Arithmetic is done at CNT_WIDTH+1 bits, unsigned.
- Up: sum = counter_out + step. An event occurs if sum > CNT_MAX.
- Down: an event occurs if step > counter_out.
- Step 0 never produces an event; the count holds.
- No event: counter_out <= sum or difference.
- Event in wrap mode:
  - up: sum - (CNT_MAX+1)
  - down: counter_out + (CNT_MAX+1) - step
- Event in saturate mode: CNT_MAX when counting up, 0 when counting down. A step already at the limit in the same direction is still an event.
- Event in one-shot mode: clamp as in saturate, and the FSM moves RUN -> DONE.
- FSM states:
  - RUN: counting allowed.
  - DONE: counter holds; enable, up_down, step and mode are ignored. Only load_en or reset returns the FSM to RUN.
  - A mode change while in DONE does not leave DONE.
- Any event sets ovf (up) or unf (down) and pulses tc.
- Flags: clr_flags clears both ovf and unf. If clr_flags and a new event occur in the same cycle, the flag for the new event is set (set wins).
- up_down, step and mode are sampled every edge. Changing them between cycles is legal and takes effect on the next step.

## Timing
- Reset (reset_n low at a rising edge): counter_out = 0, tc = 0, ovf = 0, unf = 0, done = 0, FSM = RUN. Reset mid-count or in DONE behaves identically. There is no asynchronous path.
- Latency: a load or count step is visible on counter_out one cycle after the sampling edge.
- tc rises on the same edge that registers the event result and is high for exactly one cycle.
  - Consecutive events (e.g. repeated saturating steps at the limit) give tc high on consecutive cycles.
- done rises on the same edge that registers the one-shot clamp.
- done falls on the load edge or the reset edge.
- ovf and unf rise on the event edge and fall on the edge after clr_flags is sampled.
- All outputs come directly from flops; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use CNT_WIDTH=3, CNT_MAX=5, STEP_WIDTH=2.
- Reset/load:
  - reset_n low for 2 edges -> all outputs 0.
  - Load 7 -> counter_out = 5 (clamped).
  - Load 2 with enable = 1 in the same cycle -> counter_out = 2 (load wins).
- Wrap up/down, mode 00:
  - From 4, up, step 3 -> counter_out = 1, tc pulse, ovf = 1.
  - Then down, step 2 -> counter_out = 5, tc pulse, unf = 1.
  - clr_flags -> ovf = unf = 0 on the next edge.
- Saturate, mode 01:
  - From 4, up, step 3 -> counter_out = 5, tc pulse, ovf = 1.
  - Two more steps -> counter_out stays 5, tc high for both cycles.
  - Down, step 0 -> counter_out stays 5, no tc.
- One-shot, mode 10:
  - From 1, down, step 1 for 3 cycles -> counter_out goes 0, then 0 with unf = 1, tc pulse and done = 1.
  - Further enabled cycles with up_down = 1 -> counter_out stays 0.
  - Load 3 -> done = 0 and counting resumes.
- Flag race: a down underflow in the same cycle as clr_flags = 1 -> unf = 1 and ovf = 0 afterwards.
- Mid-operation reset: in DONE with counter_out = 5, reset_n low for 1 edge -> counter_out = 0, done = 0, flags 0. Counting resumes on the next enabled cycle.

Source files
------------

// File: rtl/counter_up_down_mod_nbit.sv
// Up/down counter with programmable modulus, variable step, wrap/saturate/one-shot
// overflow handling, synchronous load, terminal-count pulse and sticky flags.
module counter_up_down_mod_nbit #(
    parameter int CNT_WIDTH  = 8,
    parameter int CNT_MAX    = 2**CNT_WIDTH - 1,
    parameter int STEP_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  load_en,
    input  logic [CNT_WIDTH-1:0]  counter_in,
    input  logic                  up_down,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [1:0]            mode,
    input  logic                  clr_flags,
    output logic [CNT_WIDTH-1:0]  counter_out,
    output logic                  tc,
    output logic                  ovf,
    output logic                  unf,
    output logic                  done
);

    localparam int                   W1    = CNT_WIDTH + 1;
    localparam logic [W1-1:0]        MAX_W = W1'(CNT_MAX);
    localparam logic [W1-1:0]        MOD_W = W1'(CNT_MAX + 1);
    localparam logic [CNT_WIDTH-1:0] MAX_C = CNT_WIDTH'(CNT_MAX);

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_tc;
    logic                  r_ovf;
    logic                  r_unf;

    logic [W1-1:0]         w_cnt_ext;
    logic [W1-1:0]         w_step_ext;
    logic [W1-1:0]         w_sum;
    logic [CNT_WIDTH-1:0]  w_diff;
    logic [CNT_WIDTH-1:0]  w_wrap_up;
    logic [CNT_WIDTH-1:0]  w_wrap_dn;
    logic [CNT_WIDTH-1:0]  w_next;
    logic [CNT_WIDTH-1:0]  w_load_val;
    logic                  w_step_en;
    logic                  w_event;
    logic                  w_clamp;

    // Arithmetic is one bit wider than the count so the up-sum never aliases.
    assign w_cnt_ext  = {1'b0, r_cnt};
    assign w_step_ext = W1'(step);
    assign w_sum      = w_cnt_ext + w_step_ext;
    assign w_diff     = r_cnt - CNT_WIDTH'(step);
    assign w_wrap_up  = CNT_WIDTH'(w_sum - MOD_W);
    assign w_wrap_dn  = CNT_WIDTH'(w_cnt_ext + MOD_W - w_step_ext);

    assign w_step_en  = enable && !load_en && (r_state == RUN);
    assign w_event    = up_down ? (w_sum > MAX_W) : (w_step_ext > w_cnt_ext);
    assign w_clamp    = (mode == 2'b01) || (mode == 2'b10);
    assign w_load_val = ({1'b0, counter_in} > MAX_W) ? MAX_C : counter_in;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_next = r_cnt;
        if (!w_event)
            w_next = up_down ? w_sum[CNT_WIDTH-1:0] : w_diff;
        else if (w_clamp)
            w_next = up_down ? MAX_C : '0;
        else
            w_next = up_down ? w_wrap_up : w_wrap_dn;
    end

    // One-shot FSM: state register
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and all state uses non-blocking assignments.
        if (!reset_n)
            r_state <= RUN;
        else
            r_state <= w_state_next;
    end

    // One-shot FSM: next state
    always_comb begin
        w_state_next = r_state;
        if (load_en)
            w_state_next = RUN;
        else if (w_step_en && w_event && (mode == 2'b10))
            w_state_next = DONE;
    end

    // One-shot FSM: outputs
    always_comb begin
        done = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_tc  <= 1'b0;
        end else if (load_en) begin
            r_cnt <= w_load_val;
            r_tc  <= 1'b0;
        end else if (w_step_en) begin
            r_cnt <= w_next;
            r_tc  <= w_event;
        end else begin
            r_tc  <= 1'b0;
        end
    end

    // Sticky flags: a new event wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_step_en && w_event && up_down)
                r_ovf <= 1'b1;
            else if (clr_flags)
                r_ovf <= 1'b0;
            if (w_step_en && w_event && !up_down)
                r_unf <= 1'b1;
            else if (clr_flags)
                r_unf <= 1'b0;
        end
    end

    assign counter_out = r_cnt;
    assign tc          = r_tc;
    assign ovf         = r_ovf;
    assign unf         = r_unf;

endmodule

// File: tb/tb_counter_up_down_mod_nbit.sv
// Self-checking bench for counter_up_down_mod_nbit (CNT_WIDTH=3, CNT_MAX=5, STEP_WIDTH=2):
// directed vectors with literal expectations plus a per-cycle arithmetic reference model.
module tb_counter_up_down_mod_nbit;

    localparam int CW = 3;
    localparam int CM = 5;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          load_en = 1'b0;
    logic [CW-1:0] counter_in = '0;
    logic          up_down = 1'b0;
    logic [SW-1:0] step = '0;
    logic [1:0]    mode = '0;
    logic          clr_flags = 1'b0;
    logic [CW-1:0] counter_out;
    logic          tc;
    logic          ovf;
    logic          unf;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    counter_up_down_mod_nbit #(
        .CNT_WIDTH (CW),
        .CNT_MAX   (CM),
        .STEP_WIDTH(SW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .load_en    (load_en),
        .counter_in (counter_in),
        .up_down    (up_down),
        .step       (step),
        .mode       (mode),
        .clr_flags  (clr_flags),
        .counter_out(counter_out),
        .tc         (tc),
        .ovf        (ovf),
        .unf        (unf),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: integer arithmetic straight from the counting rules.
    int m_cnt;
    bit m_tc, m_ovf, m_unf, m_done, m_valid;

    always @(posedge clk) begin
        int  c, s;
        bit  ev, clamp;
        c  = m_cnt;
        ev = 1'b0;
        if (!reset_n) begin
            m_cnt <= 0; m_tc <= 0; m_ovf <= 0; m_unf <= 0; m_done <= 0;
            m_valid <= 1'b1;
        end else if (load_en) begin
            m_cnt  <= (int'(counter_in) > CM) ? CM : int'(counter_in);
            m_done <= 1'b0;
            m_tc   <= 1'b0;
            if (clr_flags) begin m_ovf <= 0; m_unf <= 0; end
        end else begin
            if (enable && !m_done) begin
                clamp = (mode == 2'd1) || (mode == 2'd2);
                s     = up_down ? c + int'(step) : c - int'(step);
                ev    = (s > CM) || (s < 0);
                if (!ev)         c = s;
                else if (clamp)  c = up_down ? CM : 0;
                else             c = (s + CM + 1) % (CM + 1);
                m_cnt <= c;
                if (ev && mode == 2'd2) m_done <= 1'b1;
            end
            m_tc  <= ev;
            m_ovf <= (ev && up_down)  ? 1'b1 : (clr_flags ? 1'b0 : m_ovf);
            m_unf <= (ev && !up_down) ? 1'b1 : (clr_flags ? 1'b0 : m_unf);
        end
    end

    // Single compare process against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_cnt",  int'(counter_out), m_cnt);
            check("model_tc",   int'(tc),   int'(m_tc));
            check("model_ovf",  int'(ovf),  int'(m_ovf));
            check("model_unf",  int'(unf),  int'(m_unf));
            check("model_done", int'(done), int'(m_done));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set(input bit en, input bit ld, input int cin, input bit ud,
                       input int st, input int md, input bit clr);
        enable     = en;
        load_en    = ld;
        counter_in = CW'(cin);
        up_down    = ud;
        step       = SW'(st);
        mode       = 2'(md);
        clr_flags  = clr;
    endtask

    task automatic expect_out(input string tag, input int c, input int t,
                              input int o, input int u, input int d);
        check({tag, "_cnt"},  int'(counter_out), c);
        check({tag, "_tc"},   int'(tc),   t);
        check({tag, "_ovf"},  int'(ovf),  o);
        check({tag, "_unf"},  int'(unf),  u);
        check({tag, "_done"}, int'(done), d);
    endtask

    initial begin
        // Reset for two edges
        reset_n = 1'b0;
        set(1, 0, 0, 1, 1, 0, 0);
        tick(); tick();
        expect_out("reset", 0, 0, 0, 0, 0);
        reset_n = 1'b1;

        // Load clamps to CNT_MAX; load beats a same-cycle enable
        set(0, 1, 7, 1, 0, 0, 0); tick();
        expect_out("load_clamp", 5, 0, 0, 0, 0);
        set(1, 1, 2, 1, 3, 0, 0); tick();
        expect_out("load_wins", 2, 0, 0, 0, 0);

        // Wrap mode
        set(0, 1, 4, 1, 0, 0, 0); tick();
        set(1, 0, 0, 1, 3, 0, 0); tick();
        expect_out("wrap_up", 1, 1, 1, 0, 0);
        set(1, 0, 0, 0, 2, 0, 0); tick();
        expect_out("wrap_dn", 5, 1, 1, 1, 0);
        set(0, 0, 0, 0, 0, 0, 1); tick();
        expect_out("clr", 5, 0, 0, 0, 0);

        // Saturate mode
        set(0, 1, 4, 1, 0, 1, 0); tick();
        set(1, 0, 0, 1, 3, 1, 0); tick();
        expect_out("sat_up", 5, 1, 1, 0, 0);
        tick();
        expect_out("sat_again1", 5, 1, 1, 0, 0);
        tick();
        expect_out("sat_again2", 5, 1, 1, 0, 0);
        set(1, 0, 0, 0, 0, 1, 0); tick();
        expect_out("sat_step0", 5, 0, 1, 0, 0);

        // One-shot mode
        set(0, 0, 0, 0, 0, 0, 1); tick();
        set(0, 1, 1, 0, 0, 2, 0); tick();
        set(1, 0, 0, 0, 1, 2, 0); tick();
        expect_out("os_1", 0, 0, 0, 0, 0);
        tick();
        expect_out("os_2", 0, 1, 0, 1, 1);
        tick();
        expect_out("os_3", 0, 0, 0, 1, 1);
        set(1, 0, 0, 1, 3, 2, 0); tick(); tick();
        expect_out("os_hold", 0, 0, 0, 1, 1);
        set(1, 0, 0, 1, 3, 0, 0); tick();
        expect_out("os_modechg", 0, 0, 0, 1, 1);
        set(0, 1, 3, 1, 1, 2, 0); tick();
        expect_out("os_reload", 3, 0, 0, 1, 0);
        set(1, 0, 0, 1, 1, 2, 0); tick();
        expect_out("os_resume", 4, 0, 0, 1, 0);

        // Flag race: underflow with clr_flags in the same cycle
        set(0, 1, 5, 1, 0, 0, 1); tick();
        set(1, 0, 0, 1, 1, 0, 0); tick();
        expect_out("race_pre", 0, 1, 1, 0, 0);
        set(1, 0, 0, 0, 2, 0, 1); tick();
        expect_out("race", 4, 1, 0, 1, 0);

        // Reset while in DONE at 5
        set(0, 1, 4, 1, 0, 2, 1); tick();
        set(1, 0, 0, 1, 3, 2, 0); tick();
        expect_out("pre_rst", 5, 1, 1, 0, 1);
        reset_n = 1'b0; tick();
        expect_out("mid_rst", 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        set(1, 0, 0, 1, 2, 2, 0); tick();
        expect_out("post_rst", 2, 0, 0, 0, 0);

        // Mixed vector sweep, checked by the model every cycle (includes mode 11)
        for (int i = 0; i < 60; i++) begin
            set(i % 5 != 0, i % 13 == 0, i % 8, (i / 3) % 2, i % 4, (i / 7) % 4, i % 11 == 0);
            tick();
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
